// File: rtl/fetch.sv
// Instruction-fetch stage of the 16-bit WISC pipeline: owns the PC, drives a
// variable-latency request/ready instruction memory and the IF/ID register.
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OP  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        fetch_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DISCARD,
        S_HALTED
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        fetch_valid_q;
    logic        halted_q;
    logic        err_q;
    logic [15:0] skid_q;
    logic        skid_vld_q;

    logic [15:0] pc_inc_d;
    logic [15:0] cap_word_d;
    logic        cap_halt_d;

    // A word parked in the skid register takes precedence over the memory bus.
    always_comb begin
        pc_inc_d   = pc_q + 16'd2;
        cap_word_d = skid_vld_q ? skid_q : imem_rdata;
        cap_halt_d = (cap_word_d[15:11] == HALT_OP);
    end

    assign imem_req    = ((state_q == S_RUN) && !stall && !skid_vld_q) ||
                         (state_q == S_WAIT) || (state_q == S_DISCARD);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_plus2    = pc_plus2_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0800;
            pc_plus2_q    <= 16'h0000;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
            skid_vld_q    <= 1'b0;
        end else if (redirect_en && !err_q) begin
            pc_q          <= redirect_pc;
            fetch_valid_q <= 1'b0;
            skid_vld_q    <= 1'b0;
            if (redirect_pc[0]) begin
                err_q    <= 1'b1;
                halted_q <= 1'b1;
                state_q  <= S_HALTED;
            end else begin
                halted_q <= 1'b0;
                // A request still in flight belongs to the old path.
                if ((state_q == S_WAIT || state_q == S_DISCARD) && !imem_ready)
                    state_q <= S_DISCARD;
                else
                    state_q <= S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!stall) begin
                        if (skid_vld_q || imem_ready) begin
                            skid_vld_q    <= 1'b0;
                            instr_q       <= cap_word_d;
                            pc_plus2_q    <= pc_inc_d;
                            fetch_valid_q <= 1'b1;
                            if (cap_halt_d) begin
                                state_q  <= S_HALTED;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= pc_inc_d;
                            end
                        end else begin
                            state_q       <= S_WAIT;
                            fetch_valid_q <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        if (stall) begin
                            skid_q     <= imem_rdata;
                            skid_vld_q <= 1'b1;
                            state_q    <= S_RUN;
                        end else begin
                            instr_q       <= cap_word_d;
                            pc_plus2_q    <= pc_inc_d;
                            fetch_valid_q <= 1'b1;
                            if (cap_halt_d) begin
                                state_q  <= S_HALTED;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                pc_q    <= pc_inc_d;
                            end
                        end
                    end else if (!stall) begin
                        fetch_valid_q <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (imem_ready)
                        state_q <= S_RUN;
                end
                default: begin
                    if (!stall)
                        fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage; the bench plays the instruction memory.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        fetch_valid;
    logic        halted;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .pc_plus2    (pc_plus2),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pp2,
                          input logic e_fv);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".pc_plus2"}, pc_plus2, e_pp2);
        check({tag, ".fetch_valid"}, {15'd0, fetch_valid}, {15'd0, e_fv});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0;
        imem_rdata = 16'h0; imem_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk_if("reset", 16'h0800, 16'h0000, 1'b0);
        check("reset.halted", {15'd0, halted}, 16'd0);
        check("reset.err", {15'd0, err}, 16'd0);
        check("reset.addr", imem_addr, 16'h0000);

        // Zero-wait stream.
        imem_ready = 1'b1; imem_rdata = 16'h4000; settle();
        check("zw.req0", {15'd0, imem_req}, 16'd1);
        check("zw.addr0", imem_addr, 16'h0000);
        cyc();
        chk_if("zw0", 16'h4000, 16'h0002, 1'b1);
        check("zw.addr1", imem_addr, 16'h0002);
        imem_rdata = 16'h4001; cyc();
        chk_if("zw1", 16'h4001, 16'h0004, 1'b1);
        check("zw.addr2", imem_addr, 16'h0004);
        imem_rdata = 16'h0800; cyc();
        chk_if("zw2", 16'h0800, 16'h0006, 1'b1);
        check("zw.addr3", imem_addr, 16'h0006);

        // Two-cycle latency at 0x0010.
        imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h0010; cyc();
        redirect_en = 1'b0; settle();
        check("lat.req0", {15'd0, imem_req}, 16'd1);
        check("lat.addr0", imem_addr, 16'h0010);
        cyc();
        check("lat.fv1", {15'd0, fetch_valid}, 16'd0);
        check("lat.req1", {15'd0, imem_req}, 16'd1);
        check("lat.addr1", imem_addr, 16'h0010);
        cyc();
        check("lat.fv2", {15'd0, fetch_valid}, 16'd0);
        check("lat.req2", {15'd0, imem_req}, 16'd1);
        check("lat.addr2", imem_addr, 16'h0010);
        imem_ready = 1'b1; imem_rdata = 16'h1234; cyc();
        chk_if("lat.cap", 16'h1234, 16'h0012, 1'b1);
        check("lat.pc", imem_addr, 16'h0012);

        // Response arrives under stall and is parked.
        imem_ready = 1'b0; cyc();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 16'h5678; cyc();
        imem_ready = 1'b0; imem_rdata = 16'hBEEF;
        chk_if("stall1", 16'h1234, 16'h0012, 1'b0);
        check("stall1.req", {15'd0, imem_req}, 16'd0);
        cyc();
        chk_if("stall2", 16'h1234, 16'h0012, 1'b0);
        check("stall2.req", {15'd0, imem_req}, 16'd0);
        cyc();
        chk_if("stall3", 16'h1234, 16'h0012, 1'b0);
        stall = 1'b0; settle();
        check("skid.req", {15'd0, imem_req}, 16'd0);
        cyc();
        chk_if("skid.out", 16'h5678, 16'h0014, 1'b1);
        check("skid.addr", imem_addr, 16'h0014);

        // Redirect while waiting; late response is dropped.
        cyc();
        redirect_en = 1'b1; redirect_pc = 16'h0100; cyc();
        redirect_en = 1'b0;
        check("rd.fv", {15'd0, fetch_valid}, 16'd0);
        check("rd.addr", imem_addr, 16'h0100);
        imem_ready = 1'b1; imem_rdata = 16'hDEAD; cyc();
        chk_if("rd.drop", 16'h5678, 16'h0014, 1'b0);
        imem_rdata = 16'h4002; settle();
        check("rd.req", {15'd0, imem_req}, 16'd1);
        check("rd.addr2", imem_addr, 16'h0100);
        cyc();
        chk_if("rd.new", 16'h4002, 16'h0102, 1'b1);

        // HALT at 0x0020, then resume by redirect.
        imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h0020; cyc();
        redirect_en = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h0000; cyc();
        imem_ready = 1'b0;
        chk_if("halt.pres", 16'h0000, 16'h0022, 1'b1);
        check("halt.halted", {15'd0, halted}, 16'd1);
        check("halt.req", {15'd0, imem_req}, 16'd0);
        check("halt.pc", imem_addr, 16'h0020);
        cyc();
        chk_if("halt.hold", 16'h0000, 16'h0022, 1'b0);
        check("halt.pc2", imem_addr, 16'h0020);
        redirect_en = 1'b1; redirect_pc = 16'h0040; cyc();
        redirect_en = 1'b0; settle();
        check("resume.halted", {15'd0, halted}, 16'd0);
        check("resume.req", {15'd0, imem_req}, 16'd1);
        check("resume.addr", imem_addr, 16'h0040);

        // PC wrap.
        redirect_en = 1'b1; redirect_pc = 16'hFFFE; cyc();
        redirect_en = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h4003; cyc();
        chk_if("wrap", 16'h4003, 16'h0000, 1'b1);
        check("wrap.pc", imem_addr, 16'h0000);
        imem_rdata = 16'h4004; cyc();
        chk_if("wrap.next", 16'h4004, 16'h0002, 1'b1);

        // Misaligned redirect from WAIT; err is sticky.
        imem_ready = 1'b0; cyc();
        redirect_en = 1'b1; redirect_pc = 16'h0041; cyc();
        check("mis.err", {15'd0, err}, 16'd1);
        check("mis.halted", {15'd0, halted}, 16'd1);
        check("mis.pc", imem_addr, 16'h0041);
        check("mis.fv", {15'd0, fetch_valid}, 16'd0);
        redirect_pc = 16'h0080; cyc();
        redirect_en = 1'b0; settle();
        check("mis.sticky", {15'd0, err}, 16'd1);
        check("mis.ign", imem_addr, 16'h0041);
        check("mis.req", {15'd0, imem_req}, 16'd0);
        rst = 1'b1; cyc();
        rst = 1'b0;
        check("mis.rst.err", {15'd0, err}, 16'd0);
        check("mis.rst.halted", {15'd0, halted}, 16'd0);

        // Reset in the middle of a WAIT.
        imem_ready = 1'b1; imem_rdata = 16'h4005; cyc();
        chk_if("pre", 16'h4005, 16'h0002, 1'b1);
        imem_ready = 1'b0; cyc();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 16'hDEAD; cyc();
        rst = 1'b0;
        chk_if("rstw", 16'h0800, 16'h0000, 1'b0);
        check("rstw.halted", {15'd0, halted}, 16'd0);
        check("rstw.err", {15'd0, err}, 16'd0);
        check("rstw.addr", imem_addr, 16'h0000);
        imem_rdata = 16'h4006; cyc();
        chk_if("post", 16'h4006, 16'h0002, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
